// File: rtl/dadda_mac_pipe_if.sv
// Handshake and data bundle for dadda_mac_pipe.
// master: the side that issues operands and consumes results.
// slave:  the MAC pipeline itself.
interface dadda_mac_pipe_if #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 2*WIDTH+4
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
    logic                      acc_en;
    logic                      acc_clr;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc;
    logic                      acc_ovf;

    modport master (
        output in_valid, a, b, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, prod, acc, acc_ovf
    );

    modport slave (
        input  in_valid, a, b, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, prod, acc, acc_ovf
    );
endinterface

// File: rtl/dadda_mac_pipe.sv
// Two-stage pipelined signed multiply-accumulate.
// Stage 1: Baugh-Wooley partial products reduced by a Dadda tree to a
//          carry-save pair (z0, z1).
// Stage 2: carry-propagate add with the residual correction constant,
//          then the optional accumulate with a sticky overflow flag.
// Build option: define DADDA_MAC_SAT_EN to clamp the accumulator on
// overflow; otherwise it wraps. The port list is the same in both builds.
module dadda_mac_pipe #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 2*WIDTH+4
) (
    input  logic            clk,
    input  logic            rst,
    dadda_mac_pipe_if.slave bus
);
    localparam int PW   = 2*WIDTH;
    localparam int MAXH = 2*WIDTH + 2;
    localparam int NSTG = 16;
    // Baugh-Wooley needs 2^WIDTH + 2^(PW-1) added to the inverted-sign-row
    // partial products. The tree absorbs 2^(WIDTH-1) + 2^(PW-1) as constant
    // bits; the remaining 2^(WIDTH-1) is left for the final adder.
    localparam logic [PW-1:0] CORR = PW'(1) << (WIDTH-1);
`ifdef DADDA_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    function automatic logic add_ovf(input logic signed [ACC_W-1:0] x,
                                     input logic signed [ACC_W-1:0] y,
                                     input logic signed [ACC_W-1:0] s);
        return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] x,
                                                        input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W-1:0] s;
        s = x + y;
`ifdef DADDA_MAC_SAT_EN
        if (add_ovf(x, y, s)) s = y[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
        return s;
    endfunction

    logic          vld_p1, vld_p2;
    logic          s2_load;
    logic [PW-1:0] z0_c, z1_c;
    logic [PW-1:0] z0_p1, z1_p1;
    logic          acc_en_p1, acc_clr_p1;

    logic signed [PW-1:0]    prod_c;
    logic signed [ACC_W-1:0] p_c, acc_c;
    logic                    ovf_c;
    logic signed [PW-1:0]    prod_p2;
    logic signed [ACC_W-1:0] acc_p2;
    logic                    ovf_p2;

    assign s2_load      = vld_p1 && (!vld_p2 || bus.out_ready);
    assign bus.in_ready = !vld_p1 || s2_load;

    // Partial-product matrix and Dadda reduction down to two rows.
    always_comb begin
        logic mat [PW][MAXH];
        int   h [PW];
        int   dlist [NSTG];
        logic x, y, w;
        x = 1'b0;
        y = 1'b0;
        w = 1'b0;
        z0_c = '0;
        z1_c = '0;
        for (int c = 0; c < PW; c++) begin
            h[c] = 0;
            for (int r = 0; r < MAXH; r++) mat[c][r] = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                mat[i+j][h[i+j]] = (bus.a[i] & bus.b[j]) ^ ((i == WIDTH-1) != (j == WIDTH-1));
                h[i+j]++;
            end
        end
        mat[WIDTH-1][h[WIDTH-1]] = 1'b1;
        h[WIDTH-1]++;
        mat[PW-1][h[PW-1]] = 1'b1;
        h[PW-1]++;
        dlist[0] = 2;
        for (int k = 1; k < NSTG; k++) dlist[k] = (dlist[k-1] * 3) / 2;
        // Targets above the tallest column leave it untouched, so walking the
        // whole sequence top-down applies exactly the Dadda stages needed.
        for (int s = NSTG-1; s >= 0; s--) begin
            for (int c = 0; c < PW; c++) begin
                for (int k = 0; k < MAXH; k++) begin
                    if (h[c] > dlist[s]) begin
                        if (h[c] == dlist[s] + 1) begin
                            x = mat[c][h[c]-2];
                            y = mat[c][h[c]-1];
                            mat[c][h[c]-2] = x ^ y;
                            h[c] = h[c] - 1;
                            if (c + 1 < PW) begin
                                mat[c+1][h[c+1]] = x & y;
                                h[c+1]++;
                            end
                        end else begin
                            x = mat[c][h[c]-3];
                            y = mat[c][h[c]-2];
                            w = mat[c][h[c]-1];
                            mat[c][h[c]-3] = x ^ y ^ w;
                            h[c] = h[c] - 2;
                            if (c + 1 < PW) begin
                                mat[c+1][h[c+1]] = (x & y) | (x & w) | (y & w);
                                h[c+1]++;
                            end
                        end
                    end
                end
            end
        end
        for (int c = 0; c < PW; c++) begin
            z0_c[c] = (h[c] > 0) ? mat[c][0] : 1'b0;
            z1_c[c] = (h[c] > 1) ? mat[c][1] : 1'b0;
        end
    end

    // Pipeline occupancy; everything in flight is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (bus.in_ready) vld_p1 <= bus.in_valid;
            if (s2_load) vld_p2 <= 1'b1;
            else if (bus.out_ready) vld_p2 <= 1'b0;
        end
    end

    // ---- stage 1 boundary: carry-save pair and accumulate controls ----
    always_ff @(posedge clk) begin
        if (bus.in_ready && bus.in_valid) begin
            z0_p1      <= z0_c;
            z1_p1      <= z1_c;
            acc_en_p1  <= bus.acc_en;
            acc_clr_p1 <= bus.acc_clr;
        end
    end

    // Final add and accumulate decision for the transaction in stage 1.
    always_comb begin
        prod_c = z0_p1 + z1_p1 + CORR;
        p_c    = ACC_W'(prod_c);
        acc_c  = acc_p2;
        ovf_c  = ovf_p2;
        if (acc_clr_p1) begin
            acc_c = acc_en_p1 ? p_c : '0;
            ovf_c = 1'b0;
        end else if (acc_en_p1) begin
            acc_c = sat_add(acc_p2, p_c);
            ovf_c = ovf_p2 | add_ovf(acc_p2, p_c, acc_p2 + p_c);
        end
    end

    // ---- stage 2 boundary: product, accumulator, sticky overflow ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_p2 <= '0;
            acc_p2  <= '0;
            ovf_p2  <= 1'b0;
        end else if (s2_load) begin
            prod_p2 <= prod_c;
            acc_p2  <= acc_c;
            ovf_p2  <= ovf_c;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.prod      = prod_p2;
    assign bus.acc       = acc_p2;
    assign bus.acc_ovf   = ovf_p2;
endmodule

// File: tb/tb_dadda_mac_pipe.sv
// Scoreboard bench for dadda_mac_pipe: a 12-bit accumulator instance for the
// general behaviour and an 8-bit accumulator instance for overflow handling.
module tb_dadda_mac_pipe;
    localparam int W   = 4;
    localparam int AW  = 12;
    localparam int AW8 = 8;

    typedef struct {
        int a;
        int b;
        bit en;
        bit clr;
        int p;
        int ac;
        bit ov;
        int id;
    } txn_t;

`ifdef DADDA_MAC_SAT_EN
    localparam int OV_ACC2 = 127;
    localparam int OV_ACC3 = 127;
`else
    localparam int OV_ACC2 = -128;
    localparam int OV_ACC3 = -64;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dadda_mac_pipe_if #(.WIDTH(W), .ACC_W(AW))  bus ();
    dadda_mac_pipe_if #(.WIDTH(W), .ACC_W(AW8)) bus8 ();

    dadda_mac_pipe #(.WIDTH(W), .ACC_W(AW))  dut  (.clk(clk), .rst(rst), .bus(bus));
    dadda_mac_pipe #(.WIDTH(W), .ACC_W(AW8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    txn_t q[$];
    txn_t q8[$];
    int   total = 0;
    int   bad = 0;
    int   n_id = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: pops and compares whenever a result transfers on either DUT.
    always @(negedge clk) begin
        txn_t e;
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out: got prod=%0d with nothing outstanding", int'(bus.prod));
            end else begin
                e = q.pop_front();
                check($sformatf("prod#%0d(%0d*%0d)", e.id, e.a, e.b), int'(bus.prod), e.p);
                check($sformatf("acc#%0d", e.id), int'(bus.acc), e.ac);
                check($sformatf("ovf#%0d", e.id), int'(bus.acc_ovf), int'(e.ov));
            end
        end
        if (!rst && bus8.out_valid && bus8.out_ready) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out8: got acc=%0d with nothing outstanding", int'(bus8.acc));
            end else begin
                e = q8.pop_front();
                check($sformatf("prod8#%0d", e.id), int'(bus8.prod), e.p);
                check($sformatf("acc8#%0d", e.id), int'(bus8.acc), e.ac);
                check($sformatf("ovf8#%0d", e.id), int'(bus8.acc_ovf), int'(e.ov));
            end
        end
    end

    task automatic push(input txn_t t);
        t.id = n_id++;
        q.push_back(t);
    endtask

    task automatic send(input txn_t t);
        bit ok;
        @(negedge clk);
        bus.a = W'(t.a);
        bus.b = W'(t.b);
        bus.acc_en = t.en;
        bus.acc_clr = t.clr;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1 ok = bus.in_ready;
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        if (ok) push(t);
        else check("in_handshake", int'(bus.in_ready), 1);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic go(input int a, input int b, input bit en, input bit clr,
                      input int p, input int ac, input bit ov);
        txn_t t;
        t = '{a, b, en, clr, p, ac, ov, 0};
        send(t);
    endtask

    task automatic go8(input int a, input int b, input bit en, input bit clr,
                       input int p, input int ac, input bit ov);
        txn_t t;
        bit ok;
        t = '{a, b, en, clr, p, ac, ov, 0};
        @(negedge clk);
        bus8.a = W'(a);
        bus8.b = W'(b);
        bus8.acc_en = en;
        bus8.acc_clr = clr;
        bus8.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1 ok = bus8.in_ready;
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        if (ok) begin
            t.id = n_id++;
            q8.push_back(t);
        end else check("in_handshake8", int'(bus8.in_ready), 1);
        #1 bus8.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && (q.size() > 0 || q8.size() > 0); k++) @(negedge clk);
        check("drain_q", q.size(), 0);
        check("drain_q8", q8.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t st[4];
        int   acc_cnt;
        int   idx;
        bit   ok;

        bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;
        bus.acc_en = 1'b0;    bus.acc_clr = 1'b0;  bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0;
        bus8.acc_en = 1'b0;   bus8.acc_clr = 1'b0; bus8.out_ready = 1'b1;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_prod", int'(bus.prod), 0);
        check("rst_acc", int'(bus.acc), 0);
        check("rst_ovf", int'(bus.acc_ovf), 0);
        check("rst_out_valid8", int'(bus8.out_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(bus.in_ready), 1);

        // Clear with zero product, then two-cycle latency
        go(0, 0, 1, 1, 0, 0, 0);
        check("lat_edge1_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_edge2_out_valid", int'(bus.out_valid), 1);
        drain();

        // Directed products, accumulator untouched
        go(-6, -6, 0, 0, 36, 0, 0);
        go(3, 7, 0, 0, 21, 0, 0);
        go(-8, -8, 0, 0, 64, 0, 0);
        go(-8, 7, 0, 0, -56, 0, 0);

        // All operand pairs
        for (int ai = -8; ai < 8; ai++)
            for (int bi = -8; bi < 8; bi++)
                go(ai, bi, 0, 0, ai * bi, 0, 0);
        drain();

        // Back-to-back accumulate
        go(3, 7, 1, 1, 21, 21, 0);
        go(-6, -6, 1, 0, 36, 57, 0);
        go(-8, 7, 1, 0, -56, 1, 0);
        go(1, 1, 0, 0, 1, 1, 0);
        drain();

        // Downstream stall while streaming
        st[0] = '{2, 3, 1'b1, 1'b1, 6, 6, 1'b0, 0};
        st[1] = '{-1, 5, 1'b1, 1'b0, -5, 1, 1'b0, 0};
        st[2] = '{7, 7, 1'b1, 1'b0, 49, 50, 1'b0, 0};
        st[3] = '{-3, -4, 1'b0, 1'b0, 12, 50, 1'b0, 0};
        @(negedge clk);
        bus.out_ready = 1'b0;
        acc_cnt = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            idx = (acc_cnt < 4) ? acc_cnt : 3;
            bus.a = W'(st[idx].a);
            bus.b = W'(st[idx].b);
            bus.acc_en = st[idx].en;
            bus.acc_clr = st[idx].clr;
            bus.in_valid = 1'b1;
            #1 ok = bus.in_ready;
            @(posedge clk);
            if (ok) begin
                push(st[idx]);
                acc_cnt++;
            end
            #1;
            if (cyc >= 1) begin
                check($sformatf("stall_out_valid_c%0d", cyc), int'(bus.out_valid), 1);
                check($sformatf("stall_prod_c%0d", cyc), int'(bus.prod), 6);
                check($sformatf("stall_acc_c%0d", cyc), int'(bus.acc), 6);
            end
        end
        check("stall_accepted", acc_cnt, 2);
        check("stall_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        for (int k = acc_cnt; k < 4; k++) send(st[k]);
        drain();

        // Overflow on the 8-bit accumulator
        go8(-8, -8, 1, 1, 64, 64, 0);
        go8(-8, -8, 1, 0, 64, OV_ACC2, 1);
        go8(-8, -8, 1, 0, 64, OV_ACC3, 1);
        go8(1, 1, 1, 1, 1, 1, 0);
        drain();

        // Asynchronous reset with both stages occupied
        go(5, 5, 1, 1, 25, 25, 0);
        go(-2, 3, 1, 0, -6, 19, 0);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_prod", int'(bus.prod), 0);
        check("midrst_acc", int'(bus.acc), 0);
        check("midrst_ovf", int'(bus.acc_ovf), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        go(2, 3, 1, 0, 6, 6, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
